// File: rtl/cattrap_pkg.sv
// cattrap_pkg
//   Shared definitions for the CatTrap move-capture path.
//   IDX_W       default width of a binary row/col index
//   ERR_*       encodings reported on err_code for the last commit attempt
//   state_e     capture FSM state encoding
package cattrap_pkg;

  localparam int IDX_W = 3;

  localparam logic [1:0] ERR_OK       = 2'b00;
  localparam logic [1:0] ERR_UNSTABLE = 2'b01;
  localparam logic [1:0] ERR_INVALID  = 2'b10;
  localparam logic [1:0] ERR_BUSY     = 2'b11;

  typedef enum logic {
    ST_IDLE    = 1'b0,
    ST_PENDING = 1'b1
  } state_e;

endpackage

// File: rtl/cattrap_onehot_decode.sv
// cattrap_onehot_decode
//   Converts an 8-bit switch vector into a binary index plus a valid flag.
//   Zero-hot vectors and indices >= LIMIT are always invalid.
//   Build option CATTRAP_PRIORITY_DECODE_EN: multi-hot vectors resolve to the
//   lowest set bit. Without it, any multi-hot vector is invalid.
// Ports
//   vec_in  in   8      switch vector (bit i selects index i)
//   valid   out  1      vector decodes to a usable index
//   idx     out  IDX_W  lowest set bit position (0 when vec_in is zero)
import cattrap_pkg::*;

module cattrap_onehot_decode #(
  parameter int LIMIT = 8,
  parameter int IDX_W = cattrap_pkg::IDX_W
) (
  input  logic [7:0]       vec_in,
  output logic             valid,
  output logic [IDX_W-1:0] idx
);

  logic             found;
  logic             multi;
  logic             shape_ok;
  logic [IDX_W-1:0] idx_lo;

  always_comb begin
    found  = 1'b0;
    idx_lo = '0;
    for (int i = 0; i < 8; i++) begin
      if (vec_in[i] && !found) begin
        found  = 1'b1;
        idx_lo = IDX_W'(i);
      end
    end
  end

  // Clearing the lowest set bit leaves something behind only for multi-hot.
  assign multi = (vec_in & (vec_in - 8'd1)) != 8'd0;

`ifdef CATTRAP_PRIORITY_DECODE_EN
  assign shape_ok = found;
`else
  assign shape_ok = found && !multi;
`endif

  assign valid = shape_ok && (int'(idx_lo) < LIMIT);
  assign idx   = idx_lo;

endmodule

// File: rtl/cattrap_move_capture.sv
// cattrap_move_capture
//   Turns one-hot row/col switches and debounced commit/cancel pulses into a
//   validated binary move held behind a valid/ready handshake.
//   Build option CATTRAP_PRIORITY_DECODE_EN selects lowest-bit decoding of
//   multi-hot vectors (see cattrap_onehot_decode).
// Ports
//   clk           in   1      system clock
//   Reset         in   1      synchronous active-high reset
//   row_sw        in   8      one-hot row selection
//   col_sw        in   8      one-hot col selection
//   commit_pulse  in   1      single-cycle commit request
//   cancel_pulse  in   1      single-cycle cancel of a pending move
//   move_valid    out  1      pending move presented to the game core
//   move_ready    in   1      game core accepts the move
//   move_row      out  IDX_W  binary row of the pending move
//   move_col      out  IDX_W  binary col of the pending move
//   sel_ok        out  1      switches stable and decodable
//   err_code      out  2      result of the last commit evaluation
//
// state      | meaning
// ST_IDLE    | no move held; commit is evaluated against sel_ok
// ST_PENDING | move held on move_row/move_col until accepted or cancelled
import cattrap_pkg::*;

module cattrap_move_capture #(
  parameter int BOARD_ROWS    = 8,
  parameter int BOARD_COLS    = 8,
  parameter int STABLE_CYCLES = 1000,
  parameter int IDX_W         = cattrap_pkg::IDX_W
) (
  input  logic             clk,
  input  logic             Reset,
  input  logic [7:0]       row_sw,
  input  logic [7:0]       col_sw,
  input  logic             commit_pulse,
  input  logic             cancel_pulse,
  output logic             move_valid,
  input  logic             move_ready,
  output logic [IDX_W-1:0] move_row,
  output logic [IDX_W-1:0] move_col,
  output logic             sel_ok,
  output logic [1:0]       err_code
);

  localparam int CNT_W = $clog2(STABLE_CYCLES + 1);

  logic [7:0]       row_snap_q, row_snap_d;
  logic [7:0]       col_snap_q, col_snap_d;
  logic [CNT_W-1:0] stab_cnt_q, stab_cnt_d;
  logic             stable_q, stable_d;
  logic             sel_ok_q, sel_ok_d;
  logic [IDX_W-1:0] sel_row_q, sel_row_d;
  logic [IDX_W-1:0] sel_col_q, sel_col_d;
  state_e           state_q, state_d;
  logic             move_valid_q, move_valid_d;
  logic [IDX_W-1:0] move_row_q, move_row_d;
  logic [IDX_W-1:0] move_col_q, move_col_d;
  logic [1:0]       err_q, err_d;

  logic             stable_now;
  logic             row_ok, col_ok;
  logic [IDX_W-1:0] row_idx, col_idx;

  // Decode the snapshot, not the live pins, so validity lines up with the
  // counter that judged the same values stable.
  cattrap_onehot_decode #(.LIMIT(BOARD_ROWS), .IDX_W(IDX_W)) u_row_dec (
    .vec_in (row_snap_q),
    .valid  (row_ok),
    .idx    (row_idx)
  );

  cattrap_onehot_decode #(.LIMIT(BOARD_COLS), .IDX_W(IDX_W)) u_col_dec (
    .vec_in (col_snap_q),
    .valid  (col_ok),
    .idx    (col_idx)
  );

  assign stable_now = (stab_cnt_q == CNT_W'(STABLE_CYCLES));

  always_comb begin
    row_snap_d   = row_sw;
    col_snap_d   = col_sw;
    stab_cnt_d   = stab_cnt_q;
    stable_d     = stable_now;
    sel_ok_d     = stable_now && row_ok && col_ok;
    sel_row_d    = row_idx;
    sel_col_d    = col_idx;
    state_d      = state_q;
    move_valid_d = move_valid_q;
    move_row_d   = move_row_q;
    move_col_d   = move_col_q;
    err_d        = err_q;

    if ((row_sw != row_snap_q) || (col_sw != col_snap_q)) begin
      stab_cnt_d = '0;
    end else if (!stable_now) begin
      stab_cnt_d = stab_cnt_q + 1'b1;
    end

    // Commit evaluation uses the registered stable/sel_ok pair so the error
    // classification matches the sel_ok hint the user sees.
    case (state_q)
      ST_IDLE: begin
        if (commit_pulse) begin
          if (sel_ok_q) begin
            move_row_d   = sel_row_q;
            move_col_d   = sel_col_q;
            move_valid_d = 1'b1;
            err_d        = ERR_OK;
            state_d      = ST_PENDING;
          end else if (!stable_q) begin
            err_d = ERR_UNSTABLE;
          end else begin
            err_d = ERR_INVALID;
          end
        end
      end
      ST_PENDING: begin
        if (commit_pulse) begin
          err_d = ERR_BUSY;
        end
        // Handshake has priority over cancel; both simply release the slot.
        if ((move_valid_q && move_ready) || cancel_pulse) begin
          move_valid_d = 1'b0;
          state_d      = ST_IDLE;
        end
      end
      default: begin
        state_d      = ST_IDLE;
        move_valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (Reset) begin
      row_snap_q   <= '0;
      col_snap_q   <= '0;
      stab_cnt_q   <= '0;
      stable_q     <= 1'b0;
      sel_ok_q     <= 1'b0;
      sel_row_q    <= '0;
      sel_col_q    <= '0;
      state_q      <= ST_IDLE;
      move_valid_q <= 1'b0;
      move_row_q   <= '0;
      move_col_q   <= '0;
      err_q        <= ERR_OK;
    end else begin
      row_snap_q   <= row_snap_d;
      col_snap_q   <= col_snap_d;
      stab_cnt_q   <= stab_cnt_d;
      stable_q     <= stable_d;
      sel_ok_q     <= sel_ok_d;
      sel_row_q    <= sel_row_d;
      sel_col_q    <= sel_col_d;
      state_q      <= state_d;
      move_valid_q <= move_valid_d;
      move_row_q   <= move_row_d;
      move_col_q   <= move_col_d;
      err_q        <= err_d;
    end
  end

  assign move_valid = move_valid_q;
  assign move_row   = move_row_q;
  assign move_col   = move_col_q;
  assign sel_ok     = sel_ok_q;
  assign err_code   = err_q;

endmodule

// File: tb/tb_cattrap_move_capture.sv
// tb_cattrap_move_capture
//   Directed table of single-cycle vectors with hand-derived expectations,
//   followed by randomized traffic checked against a history-based model.
//   DUT built with STABLE_CYCLES=4, BOARD_ROWS=6, BOARD_COLS=8.
module tb_cattrap_move_capture;
  import cattrap_pkg::*;

  localparam int S  = 4;
  localparam int BR = 6;
  localparam int BC = 8;

`ifdef CATTRAP_PRIORITY_DECODE_EN
  localparam bit PRIO = 1'b1;
`else
  localparam bit PRIO = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       Reset;
  logic [7:0] row_sw, col_sw;
  logic       commit_pulse, cancel_pulse, move_ready;
  logic       move_valid, sel_ok;
  logic [2:0] move_row, move_col;
  logic [1:0] err_code;

  always #5 clk = ~clk;

  cattrap_move_capture #(
    .BOARD_ROWS(BR), .BOARD_COLS(BC), .STABLE_CYCLES(S), .IDX_W(3)
  ) dut (
    .clk(clk), .Reset(Reset), .row_sw(row_sw), .col_sw(col_sw),
    .commit_pulse(commit_pulse), .cancel_pulse(cancel_pulse),
    .move_valid(move_valid), .move_ready(move_ready),
    .move_row(move_row), .move_col(move_col),
    .sel_ok(sel_ok), .err_code(err_code)
  );

  typedef struct {
    logic [7:0] row, col;
    bit         cm, cn, rd, rs;
    bit         v;
    logic [2:0] r, c;
    bit         s;
    logic [1:0] e;
  } vec_t;

  vec_t tbl[$];
  int   n_vec = 0;
  int   n_bad = 0;

  task automatic add(input int n, input logic [7:0] row, input logic [7:0] col,
                     input bit cm, input bit cn, input bit rd, input bit rs,
                     input bit v, input int r, input int c, input bit s, input int e);
    vec_t t;
    t.row = row; t.col = col; t.cm = cm; t.cn = cn; t.rd = rd; t.rs = rs;
    t.v = v; t.r = 3'(r); t.c = 3'(c); t.s = s; t.e = 2'(e);
    repeat (n) tbl.push_back(t);
  endtask

  task automatic drive(input logic [7:0] row, input logic [7:0] col,
                       input bit cm, input bit cn, input bit rd, input bit rs);
    row_sw = row; col_sw = col; commit_pulse = cm; cancel_pulse = cn;
    move_ready = rd; Reset = rs;
  endtask

  task automatic check(input string name, input bit v, input logic [2:0] r,
                       input logic [2:0] c, input bit s, input logic [1:0] e);
    n_vec++;
    if (move_valid !== v || move_row !== r || move_col !== c || sel_ok !== s || err_code !== e) begin
      n_bad++;
      $display("FAIL %s: got valid=%0d row=%0d col=%0d sel_ok=%0d err=%0d, expected valid=%0d row=%0d col=%0d sel_ok=%0d err=%0d",
               name, move_valid, move_row, move_col, sel_ok, err_code, v, r, c, s, e);
    end
  endtask

  // Reference model: stability is judged from the recent history of sampled
  // switch values (post-reset snapshot of zero included).
  logic [15:0] hist[$];
  bit          m_pend, m_sel, m_stab;
  logic [2:0]  m_row, m_col, m_srow, m_scol;
  logic [1:0]  m_err;

  function automatic void mdec(input logic [7:0] v, input int lim,
                               output bit ok, output logic [2:0] idx);
    int lo = -1;
    for (int i = 7; i >= 0; i--) if (v[i]) lo = i;
    idx = (lo < 0) ? 3'd0 : 3'(lo);
    ok  = (lo >= 0) && (lo < lim) && (PRIO || $countones(v) == 1);
  endfunction

  task automatic mstep(input logic [7:0] r, input logic [7:0] c,
                       input bit cm, input bit cn, input bit rd, input bit rs);
    bit          st, rok, cok;
    logic [2:0]  rix, cix;
    logic [15:0] last;
    if (rs) begin
      m_pend = 0; m_sel = 0; m_stab = 0; m_row = 0; m_col = 0; m_err = ERR_OK;
      m_srow = 0; m_scol = 0;
      hist.delete();
      hist.push_back(16'h0);
      return;
    end
    last = hist[hist.size()-1];
    st = 0;
    if (hist.size() >= S + 1) begin
      st = 1;
      for (int i = 0; i <= S; i++) if (hist[hist.size()-1-i] != last) st = 0;
    end
    mdec(last[15:8], BR, rok, rix);
    mdec(last[7:0], BC, cok, cix);
    if (!m_pend) begin
      if (cm) begin
        if (m_sel) begin
          m_pend = 1; m_row = m_srow; m_col = m_scol; m_err = ERR_OK;
        end else if (!m_stab) m_err = ERR_UNSTABLE;
        else m_err = ERR_INVALID;
      end
    end else begin
      if (cm) m_err = ERR_BUSY;
      if (rd || cn) m_pend = 0;
    end
    m_stab = st;
    m_sel  = st && rok && cok;
    m_srow = rix;
    m_scol = cix;
    hist.push_back({r, c});
    if (hist.size() > S + 1) void'(hist.pop_front());
  endtask

  initial begin
    int rr, cc, eb;
    logic [7:0] rpool[8];
    logic [7:0] cpool[6];
    logic [7:0] rcur, ccur;
    bit cm, cn, rd, rs;

    rr = PRIO ? 1 : 2;
    cc = PRIO ? 3 : 4;
    eb = PRIO ? 0 : 2;

    add(1, 8'h04, 8'h10, 0,0,0,1, 0,0,0,0,0);
    add(5, 8'h04, 8'h10, 0,0,0,0, 0,0,0,0,0);
    add(1, 8'h04, 8'h10, 0,0,0,0, 0,0,0,1,0);
    add(1, 8'h04, 8'h10, 1,0,0,0, 1,2,4,1,0);
    add(1, 8'h04, 8'h10, 1,0,0,0, 1,2,4,1,3);
    add(1, 8'h04, 8'h10, 0,1,1,0, 0,2,4,1,3);
    add(1, 8'h04, 8'h08, 0,0,0,0, 0,2,4,1,3);
    add(1, 8'h04, 8'h08, 0,0,0,0, 0,2,4,0,3);
    add(1, 8'h04, 8'h08, 1,0,0,0, 0,2,4,0,1);
    add(5, 8'h06, 8'h08, 0,0,0,0, 0,2,4,0,1);
    add(1, 8'h06, 8'h08, 0,0,0,0, 0,2,4,PRIO,1);
    add(1, 8'h06, 8'h08, 1,0,0,0, PRIO,rr,cc,PRIO,eb);
    add(1, 8'h06, 8'h08, 0,1,0,0, 0,rr,cc,PRIO,eb);
    add(1, 8'h80, 8'h08, 0,0,0,0, 0,rr,cc,PRIO,eb);
    add(5, 8'h80, 8'h08, 0,0,0,0, 0,rr,cc,0,eb);
    add(1, 8'h80, 8'h08, 1,0,0,0, 0,rr,cc,0,2);
    add(5, 8'h04, 8'h10, 0,0,0,0, 0,rr,cc,0,2);
    add(1, 8'h04, 8'h10, 0,0,0,0, 0,rr,cc,1,2);
    add(1, 8'h04, 8'h10, 1,0,0,0, 1,2,4,1,0);
    add(1, 8'h04, 8'h10, 0,0,0,1, 0,0,0,0,0);
    add(4, 8'h04, 8'h10, 0,0,0,0, 0,0,0,0,0);
    add(1, 8'h04, 8'h10, 1,0,0,0, 0,0,0,0,1);
    add(1, 8'h04, 8'h10, 0,0,0,0, 0,0,0,1,1);
    add(1, 8'h04, 8'h10, 1,0,0,0, 1,2,4,1,0);
    add(1, 8'h04, 8'h10, 1,0,1,0, 0,2,4,1,3);
    add(1, 8'h04, 8'h10, 0,1,0,0, 0,2,4,1,3);

    drive(8'h00, 8'h00, 0,0,0,1);
    @(posedge clk); #1;

    for (int i = 0; i < tbl.size(); i++) begin
      drive(tbl[i].row, tbl[i].col, tbl[i].cm, tbl[i].cn, tbl[i].rd, tbl[i].rs);
      @(posedge clk); #1;
      check($sformatf("dir[%0d]", i), tbl[i].v, tbl[i].r, tbl[i].c, tbl[i].s, tbl[i].e);
    end

    rpool = '{8'h04, 8'h06, 8'h80, 8'h00, 8'h01, 8'h20, 8'h03, 8'h40};
    cpool = '{8'h10, 8'h08, 8'h01, 8'h80, 8'h00, 8'h18};
    rcur = rpool[0];
    ccur = cpool[0];
    for (int k = 0; k < 3000; k++) begin
      if ($urandom_range(9) == 0) rcur = rpool[$urandom_range(7)];
      if ($urandom_range(9) == 0) ccur = cpool[$urandom_range(5)];
      cm = ($urandom_range(5) == 0);
      cn = ($urandom_range(9) == 0);
      rd = ($urandom_range(3) == 0);
      rs = (k == 0) || ($urandom_range(399) == 0);
      drive(rcur, ccur, cm, cn, rd, rs);
      mstep(rcur, ccur, cm, cn, rd, rs);
      @(posedge clk); #1;
      check($sformatf("rnd[%0d]", k), m_pend, m_row, m_col, m_sel, m_err);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
